lsu: RTL
========

# lsu

Parametrised load/store unit for the MEM stage, replacing the single-cycle-response memory stage. It accepts one `ex_mem_t` per instruction and drives a request/ready data-memory port. It waits for the response, then aligns and sign/zero-extends load data and forwards the writeback record. It also generates store byte enables, detects misaligned and illegal-width accesses, and aborts requests that exceed a response timeout.

## Interface
Parameters:
- `XLEN`, 32: datapath width; 32 or 64 only.
- `ADDRW`, 32: address width.
- `NB`, `XLEN/8`: byte lanes (derived, not overridable).
- `TIMEOUT`, 256: maximum cycles in WAIT before the unit raises a bus fault; must be at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `ex_mem_i` in `ex_mem_t`: EX/MEM record. Upstream holds it stable while `stall_o`=1.
- `mem_wb_o` out `mem_wb_t`: MEM/WB record.
- `stall_o` out 1: freezes IF–EX.
- `dmem_req_o` out 1: request valid.
- `dmem_we_o` out 1: 1=store.
- `dmem_addr_o` out ADDRW: word/dword-aligned address, low log2(NB) bits zero.
- `dmem_wdata_o` out XLEN: store data replicated across lanes.
- `dmem_be_o` out NB: byte enables; all zero on loads.
- `dmem_ready_i` in 1: request accepted this cycle.
- `dmem_resp_i` in 1: response valid; asserted at most once per accepted request.
- `dmem_rdata_i` in XLEN: load data, valid with `dmem_resp_i`.
- `fault_o` out 1: single-cycle fault pulse.
- `fault_cause_o` out 2: 0 none, 1 misaligned, 2 bus timeout, 3 illegal width.

## Operation
- A memory op is any record with `ex_mem_i.valid && (is_load || is_store)`. Every other valid record passes straight through in the same cycle, with no stall, using the existing WB mux (ALU/CMP/MEM/PC+4).
- Width check: LD, SD and LWU are legal only when XLEN=64; otherwise the record raises cause 3.
- Alignment check: off = `alu_out[log2(NB)-1:0]`. H needs off[0]=0, W needs off[1:0]=0, D needs off[2:0]=0.
- Faulted records issue no request and do not stall. Behaviour in that cycle:
  - `fault_o`=1 and `mem_wb_o.valid`=1.
  - `rd_we` is forced to 0.
  - `debug` is passed through.
- FSM states:
  - IDLE: a legal memory op drives `dmem_req_o`=1 combinationally and sets `stall_o`=1. On `dmem_ready_i` it moves to WAIT; otherwise it stays in IDLE with the request held.
  - WAIT: `dmem_req_o`=0, `stall_o`=1, timeout counter increments.
    - On `dmem_resp_i`: `stall_o`=0, `mem_wb_o.valid`=1, return to IDLE.
    - When the counter reaches TIMEOUT-1 without a response: cause 2, `rd_we` forced to 0, valid=1, return to IDLE, and any late response is ignored.
- Load data: extract NB-lane byte/half/word at `off`, sign-extend for B/H/W (W sign-extends only when XLEN=64) and zero-extend for BU/HU/WU. D passes through.
- Store data: `rs2_v` is replicated per width. Byte enables:
  - B: `1<<off`.
  - H: `3<<off`.
  - W: `4'hF<<off`.
  - D: all ones.
- Stores complete on `dmem_resp_i` exactly like loads, with `rd_we` taken from the record (normally 0).
- `mem_wb_o.rd_s`, `rd_we` and `debug` are copied from `ex_mem_i` unless forced as above.

## Timing
- While `rst_i`=1 or at reset release:
  - FSM is in IDLE, counter is 0.
  - `dmem_req_o`, `stall_o`, `fault_o` and `mem_wb_o.valid` are 0.
  - `fault_cause_o` is 0.
- Latency is one cycle of request acceptance plus the memory latency. With ready in cycle 0 and resp in cycle 1, writeback is valid in cycle 1 and the stall lasts exactly 1 cycle (cycle 0).
- `dmem_resp_i` in the same cycle as ready is illegal and is ignored.
- Request hold rule: once `dmem_req_o`=1, addr, we, wdata and be stay stable until `dmem_ready_i`.
- Reset mid-request: the FSM returns to IDLE, the outstanding response is ignored until a new request is accepted, and the memory side must be reset together with the LSU.
- Back-to-back memory ops: the next request can be asserted in the cycle after a response, with no bubble beyond the handshake.

## Structure
- `orion_types` additions:
  - `lsu_state_e` {IDLE, WAIT}.
  - `lsu_fault_e`.
  - `FUNCT3_LS_D` and `FUNCT3_LS_WU`.
  - `rs2_v` in `ex_mem_t`.
- Sub-module `lsu_align`: combinational load extract/extend and store replicate/byte-enable, parametrised on XLEN.
- `lsu` itself holds only the FSM, the counter, fault logic and the WB mux.

## Test plan
- XLEN=32, LB at addr 0x103, rdata 0x80FF_1234, ready cycle 0, resp cycle 1:
  - dmem_addr 0x100.
  - rd_v 0xFFFF_FF80, valid in cycle 1.
  - stall high for cycle 0 only.
- XLEN=32, SH rs2 0x0000_ABCD at 0x202: wdata 0xABCD_ABCD, be 4'b1100, we=1, no writeback write.
- LW at 0x101: fault_o pulse with cause 1, no dmem_req, no stall, rd_we=0.
- ready held low 3 cycles: req and addr stable for all 4 cycles, and stall is high throughout.
- TIMEOUT=4 with no resp: cause 2 after 4 WAIT cycles, then IDLE. A late resp is ignored and the next op completes normally.
- XLEN=64, LD at 0x08, rdata 0x8000_0000_0000_0001: rd_v passes through unchanged. With XLEN=32 the same op gives cause 3.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   - lsu_state_e   : FSM states (IDLE, WAIT)
//   - lsu_fault_e   : fault cause encoding driven on fault_cause_o
//   - wb_sel_e      : writeback source select (ALU/CMP/MEM/PC+4)
//   - ex_mem_t      : EX/MEM pipeline record (fields sized for the widest XLEN)
//   - mem_wb_t      : MEM/WB pipeline record
//   - FUNCT3_LS_*   : load/store width encodings
package lsu_pkg;

  // Records carry the widest datapath so one type serves XLEN=32 and XLEN=64.
  localparam int REC_DW = 64;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_D  = 3'b011;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;
  localparam logic [2:0] FUNCT3_LS_WU = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2,
    FAULT_WIDTH    = 2'd3
  } lsu_fault_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_CMP = 2'd1,
    WB_MEM = 2'd2,
    WB_PC4 = 2'd3
  } wb_sel_e;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic              is_store;
    logic [2:0]        funct3;
    wb_sel_e           wb_sel;
    logic [REC_DW-1:0] alu_out;
    logic              cmp_out;
    logic [REC_DW-1:0] pc4;
    logic [REC_DW-1:0] rs2_v;
    logic [4:0]        rd_s;
    logic              rd_we;
    logic [31:0]       debug;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd_s;
    logic              rd_we;
    logic [REC_DW-1:0] rd_v;
    logic [31:0]       debug;
  } mem_wb_t;

  // Natural alignment check: access size is 1 << funct3[1:0] bytes.
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3[1:0])
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: data-memory request/ready port with a separate single-beat response.
//   req/we/addr/wdata/be : request, held stable by the master until ready
//   ready                : request accepted this cycle
//   resp/rdata           : response valid with load data
// Modports: master (LSU side), slave (memory side).
interface lsu_if #(
  parameter int XLEN  = 32,
  parameter int ADDRW = 32
);
  localparam int NB = XLEN / 8;

  logic             dmem_req;
  logic             dmem_we;
  logic [ADDRW-1:0] dmem_addr;
  logic [XLEN-1:0]  dmem_wdata;
  logic [NB-1:0]    dmem_be;
  logic             dmem_ready;
  logic             dmem_resp;
  logic [XLEN-1:0]  dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for the LSU.
//   i_funct3  : access width / signedness
//   i_off     : byte offset inside the XLEN word
//   i_rdata   : raw load data from memory
//   i_rs2     : store source value
//   o_load_v  : extracted and sign/zero-extended load value
//   o_wdata   : store data replicated across lanes
//   o_be      : store byte enables (caller gates for loads)
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_off,
  input  logic [XLEN-1:0]   i_rdata,
  input  logic [REC_DW-1:0] i_rs2,
  output logic [XLEN-1:0]   o_load_v,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN/8-1:0] o_be
);
  localparam int NB = XLEN / 8;

  // Work in 64 bits and truncate: W sign-extension then disappears for XLEN=32.
  logic [63:0] w_sh;
  logic [63:0] w_ld64;
  logic [63:0] w_wd64;
  logic [7:0]  w_be8;
  logic        w_sx;

  assign w_sh = 64'(i_rdata) >> {i_off, 3'b000};
  assign w_sx = ~i_funct3[2];

  always_comb begin
    case (i_funct3[1:0])
      2'd0:    w_ld64 = {{56{w_sx & w_sh[7]}},  w_sh[7:0]};
      2'd1:    w_ld64 = {{48{w_sx & w_sh[15]}}, w_sh[15:0]};
      2'd2:    w_ld64 = {{32{w_sx & w_sh[31]}}, w_sh[31:0]};
      default: w_ld64 = w_sh;
    endcase
  end

  always_comb begin
    case (i_funct3[1:0])
      2'd0: begin
        w_wd64 = {8{i_rs2[7:0]}};
        w_be8  = 8'h01 << i_off;
      end
      2'd1: begin
        w_wd64 = {4{i_rs2[15:0]}};
        w_be8  = 8'h03 << i_off;
      end
      2'd2: begin
        w_wd64 = {2{i_rs2[31:0]}};
        w_be8  = 8'h0F << i_off;
      end
      default: begin
        w_wd64 = i_rs2;
        w_be8  = 8'hFF;
      end
    endcase
  end

  assign o_load_v = w_ld64[XLEN-1:0];
  assign o_wdata  = w_wd64[XLEN-1:0];
  assign o_be     = w_be8[NB-1:0];

  logic w_unused;
  assign w_unused = ^{w_ld64, w_wd64, w_be8};

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   ex_mem_i       : EX/MEM record, held stable by upstream while stall_o=1
//   mem_wb_o       : MEM/WB record
//   stall_o        : freezes IF..EX while a memory op is outstanding
//   dmem           : lsu_if master port (request/ready, response)
//   fault_o        : single-cycle fault pulse
//   fault_cause_o  : 0 none, 1 misaligned, 2 bus timeout, 3 illegal width
//
// state | meaning
// IDLE  | no request outstanding; legal memory op drives req until ready
// WAIT  | request accepted; waiting for resp or timeout
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDRW   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  ex_mem_t     ex_mem_i,
  output mem_wb_t     mem_wb_o,
  output logic        stall_o,
  lsu_if.master       dmem,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT);

  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;

  logic [2:0]      w_f3;
  logic [2:0]      w_off;
  logic            w_mem_op;
  logic            w_bad_width;
  logic            w_misalign;
  logic            w_legal_op;
  logic            w_cnt_last;
  logic [XLEN-1:0] w_load_v;
  logic [XLEN-1:0] w_wdata;
  logic [NB-1:0]   w_be;
  logic            w_req;
  lsu_fault_e      w_cause;

  assign w_f3       = ex_mem_i.funct3;
  assign w_off      = 3'(ex_mem_i.alu_out[OFFW-1:0]);
  assign w_mem_op   = ex_mem_i.valid && (ex_mem_i.is_load || ex_mem_i.is_store);
  assign w_misalign = lsu_misaligned(w_f3, w_off);
  assign w_legal_op = w_mem_op && !w_bad_width && !w_misalign;
  assign w_cnt_last = (r_cnt == CNTW'(TIMEOUT - 1));

  // Doubleword and WU exist only on RV64; stores have no unsigned forms.
  always_comb begin
    w_bad_width = 1'b0;
    if (ex_mem_i.is_load)
      w_bad_width = (w_f3 == 3'b111) ||
                    ((XLEN == 32) && ((w_f3 == FUNCT3_LS_D) || (w_f3 == FUNCT3_LS_WU)));
    else if (ex_mem_i.is_store)
      w_bad_width = w_f3[2] || ((XLEN == 32) && (w_f3 == FUNCT3_LS_D));
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3 (w_f3),
    .i_off    (w_off),
    .i_rdata  (dmem.dmem_rdata),
    .i_rs2    (ex_mem_i.rs2_v),
    .o_load_v (w_load_v),
    .o_wdata  (w_wdata),
    .o_be     (w_be)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_legal_op && dmem.dmem_ready)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        // Response in the ready cycle never reaches here: IDLE ignores resp.
        if (dmem.dmem_resp || w_cnt_last)
          w_state_nxt = IDLE;
        else
          w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req          = 1'b0;
    stall_o        = 1'b0;
    fault_o        = 1'b0;
    w_cause        = FAULT_NONE;
    mem_wb_o       = '0;
    mem_wb_o.rd_s  = ex_mem_i.rd_s;
    mem_wb_o.rd_we = ex_mem_i.rd_we;
    mem_wb_o.debug = ex_mem_i.debug;

    if (w_mem_op) begin
      mem_wb_o.rd_v = REC_DW'(w_load_v);
    end else begin
      case (ex_mem_i.wb_sel)
        WB_ALU:  mem_wb_o.rd_v = REC_DW'(ex_mem_i.alu_out[XLEN-1:0]);
        WB_CMP:  mem_wb_o.rd_v = REC_DW'(ex_mem_i.cmp_out);
        WB_MEM:  mem_wb_o.rd_v = REC_DW'(w_load_v);
        default: mem_wb_o.rd_v = REC_DW'(ex_mem_i.pc4[XLEN-1:0]);
      endcase
    end

    if (!rst_i) begin
      case (r_state)
        IDLE: begin
          if (ex_mem_i.valid && !w_mem_op) begin
            mem_wb_o.valid = 1'b1;
          end else if (w_mem_op && (w_bad_width || w_misalign)) begin
            fault_o        = 1'b1;
            w_cause        = w_bad_width ? FAULT_WIDTH : FAULT_MISALIGN;
            mem_wb_o.valid = 1'b1;
            mem_wb_o.rd_we = 1'b0;
          end else if (w_mem_op) begin
            w_req   = 1'b1;
            stall_o = 1'b1;
          end
        end
        WAIT: begin
          if (dmem.dmem_resp) begin
            mem_wb_o.valid = 1'b1;
          end else if (w_cnt_last) begin
            fault_o        = 1'b1;
            w_cause        = FAULT_TIMEOUT;
            mem_wb_o.valid = 1'b1;
            mem_wb_o.rd_we = 1'b0;
          end else begin
            stall_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fault_cause_o   = w_cause;
  assign dmem.dmem_req   = w_req;
  assign dmem.dmem_we    = ex_mem_i.is_store;
  assign dmem.dmem_addr  = {ex_mem_i.alu_out[ADDRW-1:OFFW], {OFFW{1'b0}}};
  assign dmem.dmem_wdata = w_wdata;
  assign dmem.dmem_be    = ex_mem_i.is_store ? w_be : '0;

  logic w_unused;
  assign w_unused = ^{ex_mem_i.alu_out, ex_mem_i.pc4};

endmodule
